fifo_rr_wr_arbiter: RTL and testbench
=====================================

Name: fifo_rr_wr_arbiter

Overview:
Round-robin write arbiter that shares one synch_fifo write port between NUM_REQ producers. It grants at most one requester per cycle and registers the winner's data onto the FIFO write port. It tracks free FIFO slots with a credit counter, so it never issues a write the FIFO would flag as overflow. Sits directly in front of the FIFO. Reads are reported back to it by the FIFO consumer.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
DATA_WIDTH, 12, data word width; matches FIFO DATA_WIDTH
DEPTH, 16, FIFO depth; initial credit value
ID_WIDTH, $clog2(NUM_REQ), source-index width
CRD_WIDTH, $clog2(DEPTH+1), credit counter width

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  asynchronous, active-high reset; same net also resets the FIFO
req_i  input  NUM_REQ  per-requester request; held with data until granted
data_i  input  NUM_REQ*DATA_WIDTH  packed data, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
gnt_o  output  NUM_REQ  combinational one-hot grant; transfer occurs at the edge ending a cycle with gnt_o[k]=1
fifo_wr_en_o  output  1  registered FIFO write enable
fifo_wdata_o  output  DATA_WIDTH  registered FIFO write data
fifo_src_o  output  ID_WIDTH  registered index of the requester whose word is on fifo_wdata_o
fifo_rd_ok_i  input  1  one-cycle pulse per successful FIFO read (rd_en and not empty)
fifo_full_i  input  1  FIFO full flag; used only for the error check
credit_o  output  CRD_WIDTH  current free-slot credit
err_o  output  1  sticky protocol error

Behaviour:
- Reset (async assert, sync-safe deassert by system):
  - fifo_wr_en_o=0, fifo_wdata_o=0, fifo_src_o=0, err_o=0.
  - credit=DEPTH.
  - Priority pointer ptr=0.
  - gnt_o=0 while rst_i is high.
- Grant (combinational):
  - If credit==0, gnt_o=0.
  - Otherwise, grant the first requester with req_i set, searching upward from ptr modulo NUM_REQ.
  - If no requester is asserting req_i, gnt_o=0.
- Pointer update: on any grant to index k, ptr <= (k+1) mod NUM_REQ. With no grant, ptr holds.
- Write pipeline (1-cycle latency): on the edge ending a grant cycle:
  - fifo_wr_en_o<=1, fifo_wdata_o<=data_i[k], fifo_src_o<=k.
  - With no grant, fifo_wr_en_o<=0; fifo_wdata_o and fifo_src_o hold.
- Credit, per edge:
  - grant and no fifo_rd_ok_i: credit-1.
  - fifo_rd_ok_i and no grant: credit+1.
  - both or neither: unchanged.
- Credit bounds:
  - If credit==DEPTH and fifo_rd_ok_i=1 with no grant, credit holds at DEPTH and err_o<=1.
  - Credit never goes below 0, since grant is impossible at 0.
- Requester handshake:
  - A requester drops req_i, or presents its next word, in the cycle after gnt_o.
  - A requester may not withdraw req_i before it is granted. Withdrawal is not checked and is not an error.
- Error: err_o<=1 if fifo_wr_en_o=1 while fifo_full_i=1. err_o stays set until reset.
- Throughput: one write per cycle sustained while credit>0. Up to DEPTH back-to-back writes from empty.
- Fairness: with all requesters asserting, grants rotate 0,1,...,NUM_REQ-1. No requester waits more than NUM_REQ-1 grants.
- Reset mid-operation: an in-flight registered write is discarded (fifo_wr_en_o drops immediately); the FIFO is reset by the same rst_i.

Decomposition:
- Shared package fifo_arb_pkg holds:
  - default DATA_WIDTH/DEPTH constants;
  - a function rr_pick(req, ptr) that returns the one-hot grant.
- One natural sub-module: rr_priority_pick, the combinational rotate-priority encoder (req, ptr -> one-hot gnt, index). The top holds the credit counter, pointer and write-port registers.

Test Plan:
1. Reset: assert rst_i -> credit_o=16, gnt_o=0, fifo_wr_en_o=0, err_o=0, immediately without a clock edge.
2. req_i=4'b0001, data 0xABC held for 20 cycles, no reads -> gnt_o[0] for 16 cycles, fifo_wr_en_o/fifo_wdata_o=0xABC one cycle later, credit_o reaches 0, then gnt_o=0 and no overflow at the FIFO.
3. req_i=4'b1111 continuous with reads each cycle -> grant order 0,1,2,3,0,1; fifo_src_o follows one cycle later; credit_o constant.
4. credit_o=0, one fifo_rd_ok_i pulse with req_i=4'b0100 -> credit 1, gnt_o=4'b0100 next cycle, credit back to 0. Grant and read in the same cycle -> credit unchanged.
5. Assert rst_i mid-burst, between edges -> fifo_wr_en_o=0 and credit_o=16 at once; after release, arbitration restarts at requester 0.
6. Force fifo_full_i=1 during a fifo_wr_en_o cycle -> err_o=1 and stays 1 until reset. Spurious fifo_rd_ok_i at credit 16 -> credit stays 16 and err_o=1.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared constants and the rotate-priority pick function for the FIFO write arbiter.
package fifo_arb_pkg;

  localparam int DEF_DATA_WIDTH = 12;
  localparam int DEF_DEPTH      = 16;
  localparam int MAX_REQ        = 32;
  localparam int MAX_IDX_W      = 5;

  // One-hot grant for the first set bit of req at or above ptr, wrapping at n.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                 input int ptr,
                                                 input int n);
    logic [MAX_REQ-1:0]   gnt;
    logic [MAX_IDX_W:0]   idx;
    gnt = '0;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (i < n && gnt == '0) begin
        idx = (MAX_IDX_W+1)'(ptr) + (MAX_IDX_W+1)'(i);
        if (idx >= (MAX_IDX_W+1)'(n)) idx = idx - (MAX_IDX_W+1)'(n);
        if (req[idx[MAX_IDX_W-1:0]]) gnt[idx[MAX_IDX_W-1:0]] = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotate-priority encoder: one-hot grant plus binary index of the winner.
module rr_priority_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]  gnt,
  output logic [ID_WIDTH-1:0] idx,
  output logic                valid
);

  logic [MAX_REQ-1:0] req_ext;
  logic [MAX_REQ-1:0] gnt_ext;

  always_comb begin
    req_ext = '0;
    req_ext[NUM_REQ-1:0] = req;
    gnt_ext = rr_pick(req_ext, int'(ptr), NUM_REQ);
    gnt     = gnt_ext[NUM_REQ-1:0];
    valid   = |gnt_ext;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_ext[k]) idx = ID_WIDTH'(k);
    end
  end

endmodule

// File: rtl/fifo_rr_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port; credit counter mirrors free FIFO slots.
module fifo_rr_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ID_WIDTH   = $clog2(NUM_REQ),
  parameter int CRD_WIDTH  = $clog2(DEPTH+1)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic                          fifo_wr_en_o,
  output logic [DATA_WIDTH-1:0]         fifo_wdata_o,
  output logic [ID_WIDTH-1:0]           fifo_src_o,
  input  logic                          fifo_rd_ok_i,
  input  logic                          fifo_full_i,
  output logic [CRD_WIDTH-1:0]          credit_o,
  output logic                          err_o
);

  logic [ID_WIDTH-1:0]   ptr;
  logic [ID_WIDTH-1:0]   pick_idx;
  logic [NUM_REQ-1:0]    pick_gnt;
  logic                  pick_valid;
  logic                  grant;
  logic [CRD_WIDTH-1:0]  credit;
  logic [DATA_WIDTH-1:0] sel_data;

  rr_priority_pick #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .req   (req_i),
    .ptr   (ptr),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // No grant at zero credit keeps the FIFO from ever seeing an overflowing write.
  assign grant    = pick_valid && (credit != '0) && !rst_i;
  assign gnt_o    = grant ? pick_gnt : '0;
  assign credit_o = credit;

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick_idx == ID_WIDTH'(k)) sel_data = data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fifo_wr_en_o <= 1'b0;
      fifo_wdata_o <= '0;
      fifo_src_o   <= '0;
      ptr          <= '0;
      credit       <= CRD_WIDTH'(DEPTH);
      err_o        <= 1'b0;
    end else begin
      fifo_wr_en_o <= grant;
      if (grant) begin
        fifo_wdata_o <= sel_data;
        fifo_src_o   <= pick_idx;
        ptr          <= (pick_idx == ID_WIDTH'(NUM_REQ-1)) ? '0 : pick_idx + 1'b1;
      end
      if (grant && !fifo_rd_ok_i) begin
        credit <= credit - 1'b1;
      end else if (fifo_rd_ok_i && !grant) begin
        // A read reported with the FIFO already empty is a consumer protocol error.
        if (credit == CRD_WIDTH'(DEPTH)) err_o <= 1'b1;
        else credit <= credit + 1'b1;
      end
      if (fifo_wr_en_o && fifo_full_i) err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_rr_wr_arbiter.sv
// Self-checking bench: directed sequences, a vector table, and a write-port scoreboard.
module tb_fifo_rr_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [11:0] dat [4];
  logic [47:0] data;
  logic [3:0]  gnt;
  logic        wr_en;
  logic [11:0] wdata;
  logic [1:0]  src;
  logic        rd_ok;
  logic        full;
  logic [4:0]  credit;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [11:0] d;
    logic [1:0]  s;
  } wr_t;
  wr_t sb_q[$];

  typedef struct {
    logic [3:0] req;
    logic       rd;
    logic [3:0] exp_gnt;
    logic [4:0] exp_credit;
  } vec_t;
  vec_t vecs[10];

  int m_credit = 16;
  int m_ptr    = 0;

  assign data = {dat[3], dat[2], dat[1], dat[0]};

  always #5 clk = ~clk;

  fifo_rr_wr_arbiter dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_i        (req),
    .data_i       (data),
    .gnt_o        (gnt),
    .fifo_wr_en_o (wr_en),
    .fifo_wdata_o (wdata),
    .fifo_src_o   (src),
    .fifo_rd_ok_i (rd_ok),
    .fifo_full_i  (full),
    .credit_o     (credit),
    .err_o        (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_pick(input logic [3:0] r, input int p, input int c);
    if (c == 0) return -1;
    for (int i = 0; i < 4; i++) begin
      if (r[(p + i) % 4]) return (p + i) % 4;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model and scoreboard, evaluated mid-cycle on the falling edge.
  always @(negedge clk) begin
    int   k;
    wr_t  w;
    if (rst) begin
      m_credit = 16;
      m_ptr    = 0;
      sb_q.delete();
    end else begin
      check("credit_model", 32'(credit), 32'(m_credit));
      if (wr_en) begin
        if (sb_q.size() == 0) begin
          check("unexpected_write", 32'(wr_en), 32'd0);
        end else begin
          w = sb_q.pop_front();
          check("sb_wdata", 32'(wdata), 32'(w.d));
          check("sb_src", 32'(src), 32'(w.s));
        end
      end
      k = exp_pick(req, m_ptr, m_credit);
      check("gnt_model", 32'(gnt), (k < 0) ? 32'd0 : (32'd1 << k));
      if (k >= 0) begin
        w.d = dat[k];
        w.s = 2'(k);
        sb_q.push_back(w);
        m_ptr = (k + 1) % 4;
        if (!rd_ok) m_credit--;
      end else if (rd_ok && m_credit < 16) begin
        m_credit++;
      end
    end
  end

  initial begin
    int n_gnt;
    int n_wr;

    for (int k = 0; k < 4; k++) dat[k] = 12'h100 + 12'(k * 17);
    rd_ok = 1'b0;
    full  = 1'b0;
    req   = 4'b1111;
    rst   = 1'b1;
    #2;
    // Reset values, no clock edge yet
    check("rst_credit", 32'(credit), 32'd16);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_wdata", 32'(wdata), 32'd0);
    check("rst_src", 32'(src), 32'd0);
    req = 4'b0000;
    tick();
    rst = 1'b0;

    // Single requester, no reads: exactly DEPTH grants then stall
    tick();
    dat[0] = 12'hABC;
    req    = 4'b0001;
    n_gnt  = 0;
    n_wr   = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (gnt == 4'b0001) n_gnt++;
      if (wr_en) n_wr++;
      tick();
    end
    check("burst_grants", 32'(n_gnt), 32'd16);
    check("burst_writes", 32'(n_wr), 32'd16);
    check("burst_credit0", 32'(credit), 32'd0);
    check("burst_gnt_stall", 32'(gnt), 32'd0);

    // One read at zero credit lets exactly one more grant through
    req    = 4'b0100;
    dat[2] = 12'h555;
    rd_ok  = 1'b1;
    #1 check("c0_gnt_A", 32'(gnt), 32'd0);
    tick();
    rd_ok = 1'b0;
    #1 check("c1_credit_B", 32'(credit), 32'd1);
    check("c1_gnt_B", 32'(gnt), 32'b0100);
    tick();
    #1 check("c0_credit_C", 32'(credit), 32'd0);
    check("c0_gnt_C", 32'(gnt), 32'd0);
    rd_ok = 1'b1;
    tick();
    #1 check("both_gnt_E", 32'(gnt), 32'b0100);
    tick();
    rd_ok = 1'b0;
    req   = 4'b0000;
    #1 check("both_credit_F", 32'(credit), 32'd1);

    // Drain back to full credit
    rd_ok = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    rd_ok = 1'b0;
    #1 check("drain_credit", 32'(credit), 32'd16);
    check("drain_err", 32'(err), 32'd0);

    // Reset in the middle of a burst
    req = 4'b1111;
    tick();
    tick();
    tick();
    #2 check("mid_wr_en_before", 32'(wr_en), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_wr_en", 32'(wr_en), 32'd0);
    check("mid_rst_credit", 32'(credit), 32'd16);
    check("mid_rst_gnt", 32'(gnt), 32'd0);
    req = 4'b0000;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Rotation with reads every cycle: credit stays at DEPTH
    vecs[0] = '{4'b1111, 1'b1, 4'b0001, 5'd16};
    vecs[1] = '{4'b1111, 1'b1, 4'b0010, 5'd16};
    vecs[2] = '{4'b1111, 1'b1, 4'b0100, 5'd16};
    vecs[3] = '{4'b1111, 1'b1, 4'b1000, 5'd16};
    vecs[4] = '{4'b1111, 1'b1, 4'b0001, 5'd16};
    vecs[5] = '{4'b1111, 1'b1, 4'b0010, 5'd16};
    vecs[6] = '{4'b1010, 1'b1, 4'b1000, 5'd16};
    vecs[7] = '{4'b0011, 1'b1, 4'b0001, 5'd16};
    vecs[8] = '{4'b0000, 1'b0, 4'b0000, 5'd16};
    vecs[9] = '{4'b0100, 1'b1, 4'b0100, 5'd16};
    for (int i = 0; i < 10; i++) begin
      req   = vecs[i].req;
      rd_ok = vecs[i].rd;
      dat[i % 4] = 12'h200 + 12'(i);
      #1;
      check($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vecs[i].exp_gnt));
      check($sformatf("vec%0d_credit", i), 32'(credit), 32'(vecs[i].exp_credit));
      tick();
    end
    req   = 4'b0000;
    rd_ok = 1'b0;
    check("rot_err", 32'(err), 32'd0);

    // Write while FIFO reports full sets a sticky error
    req = 4'b0001;
    tick();
    req  = 4'b0000;
    full = 1'b1;
    #1 check("full_wr_en", 32'(wr_en), 32'd1);
    tick();
    full = 1'b0;
    #1 check("full_err_set", 32'(err), 32'd1);
    tick();
    tick();
    #1 check("full_err_sticky", 32'(err), 32'd1);
    rst = 1'b1;
    #1;
    check("err_cleared", 32'(err), 32'd0);
    check("err_rst_credit", 32'(credit), 32'd16);
    tick();
    rst = 1'b0;
    tick();

    // Spurious read at full credit
    rd_ok = 1'b1;
    tick();
    rd_ok = 1'b0;
    #1;
    check("spur_credit", 32'(credit), 32'd16);
    check("spur_err", 32'(err), 32'd1);
    tick();
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
